// File: rtl/cpu_pkg.sv
// Shared little-cpu types: memory op/width encodings, accessor FSM states,
// and small helpers for sub-word address handling.
package cpu_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } mem_width_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } accessor_state_t;

  // Offset the access actually uses: misaligned halves/words round down.
  function automatic logic [1:0] aligned_offset(mem_width_t width, logic [1:0] addr_lo);
    case (width)
      WIDTH_BYTE: aligned_offset = addr_lo;
      WIDTH_HALF: aligned_offset = {addr_lo[1], 1'b0};
      default:    aligned_offset = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_width_t width, logic [1:0] addr_lo);
    case (width)
      WIDTH_BYTE: is_misaligned = 1'b0;
      WIDTH_HALF: is_misaligned = addr_lo[0];
      default:    is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extraction: selects the addressed byte/half/word lane from the
// bus read word and sign- or zero-extends it to 32 bits.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  mem_width_t  width_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    case (width_i)
      WIDTH_BYTE: result_o = unsigned_i ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      WIDTH_HALF: result_o = unsigned_i ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default:    result_o = shifted;
    endcase
  end

endmodule

// File: rtl/accessor.sv
// Memory-access pipeline stage: runs loads/stores over a valid/ready data bus
// and emits one-cycle results to writeback. Optional: ACCESSOR_MISALIGN_TRAP_EN.
module accessor
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            executor_valid,
  output logic            accessor_ready,
  input  logic [4:0]      executor_rd,
  input  logic [XLEN-1:0] executor_rd_data,
  input  logic [1:0]      executor_mem_op,
  input  logic [1:0]      executor_mem_width,
  input  logic            executor_mem_unsigned,
  input  logic [XLEN-1:0] executor_mem_addr,
  input  logic [XLEN-1:0] executor_mem_data,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            accessor_valid,
  output logic [4:0]      accessor_rd,
`ifdef ACCESSOR_MISALIGN_TRAP_EN
  output logic            accessor_trap,
`endif
  output logic [XLEN-1:0] accessor_rd_data
);

  accessor_state_t state_q, state_d;

  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic [4:0]      rd_q,   rd_d;
  mem_width_t      width_q, width_d;
  logic            uns_q,  uns_d;
  logic [1:0]      off_q,  off_d;

  logic            out_valid_q, out_valid_d;
  logic [4:0]      out_rd_q,    out_rd_d;
  logic [XLEN-1:0] out_data_q,  out_data_d;

`ifdef ACCESSOR_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic            misaligned;
`endif

  mem_op_t         op_in;
  mem_width_t      width_in;
  logic [1:0]      off_in;
  logic [3:0]      store_strb;
  logic [XLEN-1:0] store_data;
  logic [31:0]     load_result;

  assign op_in    = mem_op_t'(executor_mem_op);
  assign width_in = mem_width_t'(executor_mem_width);
  assign off_in   = aligned_offset(width_in, executor_mem_addr[1:0]);

`ifdef ACCESSOR_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(width_in, executor_mem_addr[1:0]);
`endif

  // Store lanes: replicate data across the word so the strobes pick the lane.
  always_comb begin
    case (width_in)
      WIDTH_BYTE: begin
        store_strb = 4'b0001 << off_in;
        store_data = {4{executor_mem_data[7:0]}};
      end
      WIDTH_HALF: begin
        store_strb = 4'b0011 << off_in;
        store_data = {2{executor_mem_data[15:0]}};
      end
      default: begin
        store_strb = 4'b1111;
        store_data = executor_mem_data;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata_i    (mem_rdata),
    .offset_i   (off_q),
    .width_i    (width_q),
    .unsigned_i (uns_q),
    .result_o   (load_result)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    width_d     = width_q;
    uns_d       = uns_q;
    off_d       = off_q;
    out_valid_d = 1'b0;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
    trap_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (executor_valid) begin
          if (op_in != MEM_LOAD && op_in != MEM_STORE) begin
            out_valid_d = 1'b1;
            out_rd_d    = executor_rd;
            out_data_d  = executor_rd_data;
          end
`ifdef ACCESSOR_MISALIGN_TRAP_EN
          else if (misaligned) begin
            out_valid_d = 1'b1;
            out_rd_d    = 5'd0;
            out_data_d  = executor_mem_addr;
            trap_d      = 1'b1;
          end
`endif
          else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = {executor_mem_addr[XLEN-1:2], 2'b00};
            mem_wstrb_d = (op_in == MEM_STORE) ? store_strb : 4'b0000;
            mem_wdata_d = (op_in == MEM_STORE) ? store_data : '0;
            // Stores retire to x0 so writeback needs no special case.
            rd_d        = (op_in == MEM_STORE) ? 5'd0 : executor_rd;
            width_d     = width_in;
            uns_d       = executor_mem_unsigned;
            off_d       = off_in;
            state_d     = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          out_valid_d = 1'b1;
          out_rd_d    = rd_q;
          out_data_d  = (mem_wstrb_q == 4'b0000) ? load_result : '0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      rd_q        <= 5'd0;
      width_q     <= WIDTH_BYTE;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      out_valid_q <= 1'b0;
      out_rd_q    <= 5'd0;
      out_data_q  <= '0;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      width_q     <= width_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

  assign accessor_ready   = (state_q == ST_IDLE);
  assign mem_valid        = mem_valid_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wstrb        = mem_wstrb_q;
  assign mem_wdata        = mem_wdata_q;
  assign accessor_valid   = out_valid_q;
  assign accessor_rd      = out_rd_q;
  assign accessor_rd_data = out_data_q;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
  assign accessor_trap    = trap_q;
`endif

endmodule

// File: tb/tb_accessor.sv
// Self-checking bench for accessor: a scoreboard queue holds expected
// writeback results; a monitor pops and compares on every accessor_valid.
module tb_accessor;
  import cpu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        executor_valid;
  logic        accessor_ready;
  logic [4:0]  executor_rd;
  logic [31:0] executor_rd_data;
  logic [1:0]  executor_mem_op;
  logic [1:0]  executor_mem_width;
  logic        executor_mem_unsigned;
  logic [31:0] executor_mem_addr;
  logic [31:0] executor_mem_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        accessor_valid;
  logic [4:0]  accessor_rd;
  logic [31:0] accessor_rd_data;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
  logic        accessor_trap;
`endif

  accessor dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .executor_valid        (executor_valid),
    .accessor_ready        (accessor_ready),
    .executor_rd           (executor_rd),
    .executor_rd_data      (executor_rd_data),
    .executor_mem_op       (executor_mem_op),
    .executor_mem_width    (executor_mem_width),
    .executor_mem_unsigned (executor_mem_unsigned),
    .executor_mem_addr     (executor_mem_addr),
    .executor_mem_data     (executor_mem_data),
    .mem_valid             (mem_valid),
    .mem_ready             (mem_ready),
    .mem_addr              (mem_addr),
    .mem_wstrb             (mem_wstrb),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata),
    .accessor_valid        (accessor_valid),
    .accessor_rd           (accessor_rd),
`ifdef ACCESSOR_MISALIGN_TRAP_EN
    .accessor_trap         (accessor_trap),
`endif
    .accessor_rd_data      (accessor_rd_data)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        trap;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && accessor_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result_rd", {27'd0, accessor_rd}, {27'd0, e.rd});
        if (e.chk_data) check("result_data", accessor_rd_data, e.data);
`ifdef ACCESSOR_MISALIGN_TRAP_EN
        check("result_trap", {31'd0, accessor_trap}, {31'd0, e.trap});
`endif
      end
    end
  end

  function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] data,
                              input logic chk_data, input logic trap);
    exp_t e;
    e.rd = rd; e.data = data; e.chk_data = chk_data; e.trap = trap;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!accessor_ready && n < 100) begin
      step();
      n++;
    end
    if (!accessor_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [1:0] width, input logic uns,
                          input logic [4:0] rd, input logic [31:0] rd_data,
                          input logic [31:0] addr, input logic [31:0] sdata);
    executor_valid        = 1'b1;
    executor_mem_op       = op;
    executor_mem_width    = width;
    executor_mem_unsigned = uns;
    executor_rd           = rd;
    executor_rd_data      = rd_data;
    executor_mem_addr     = addr;
    executor_mem_data     = sdata;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] width, input logic uns,
                       input logic [4:0] rd, input logic [31:0] rd_data,
                       input logic [31:0] addr, input logic [31:0] sdata);
    wait_ready();
    drive_op(op, width, uns, rd, rd_data, addr, sdata);
    step();
    executor_valid = 1'b0;
  endtask

  // Bus responder: checks the request, holds it for `waits` cycles, completes it.
  task automatic respond(input string tag, input int waits, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata, input logic chk_wdata);
    int n = 0;
    while (!mem_valid && n < 100) begin
      step();
      n++;
    end
    if (!mem_valid) check({tag, "_bus_timeout"}, 32'd0, 32'd1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_strb});
    if (chk_wdata) check({tag, "_wdata"}, mem_wdata, exp_wdata);
    check({tag, "_busy"}, {31'd0, accessor_ready}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      step();
      check({tag, "_hold_valid"}, {31'd0, mem_valid}, 32'd1);
      check({tag, "_hold_addr"}, mem_addr, exp_addr);
      check({tag, "_hold_ready"}, {31'd0, accessor_ready}, 32'd0);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check({tag, "_drop_valid"}, {31'd0, mem_valid}, 32'd0);
    check({tag, "_done_pulse"}, {31'd0, accessor_valid}, 32'd1);
    check({tag, "_ready_back"}, {31'd0, accessor_ready}, 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [1:0] width, input logic uns,
                         input logic [4:0] rd, input logic [31:0] addr, input int waits,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [31:0] exp_result);
    sb.push_back(mk(rd, exp_result, 1'b1, 1'b0));
    issue(MEM_LOAD, width, uns, rd, 32'h0, addr, 32'h0);
    respond(tag, waits, rdata, exp_addr, 4'b0000, 32'h0, 1'b0);
  endtask

  task automatic do_store(input string tag, input logic [1:0] width, input logic [31:0] addr,
                          input logic [31:0] sdata, input int waits,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
    sb.push_back(mk(5'd0, 32'h0, 1'b0, 1'b0));
    issue(MEM_STORE, width, 1'b0, 5'd3, 32'h0, addr, sdata);
    respond(tag, waits, 32'hFFFF_FFFF, exp_addr, exp_strb, exp_wdata, 1'b1);
  endtask

  initial begin
    reset_n               = 1'b0;
    executor_valid        = 1'b0;
    executor_rd           = 5'd0;
    executor_rd_data      = 32'h0;
    executor_mem_op       = MEM_NONE;
    executor_mem_width    = WIDTH_BYTE;
    executor_mem_unsigned = 1'b0;
    executor_mem_addr     = 32'h0;
    executor_mem_data     = 32'h0;
    mem_ready             = 1'b0;
    mem_rdata             = 32'h0;

    #12;
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_acc_valid", {31'd0, accessor_valid}, 32'd0);
    check("rst_acc_rd", {27'd0, accessor_rd}, 32'd0);
    check("rst_acc_data", accessor_rd_data, 32'h0);
    check("rst_ready", {31'd0, accessor_ready}, 32'd1);
`ifdef ACCESSOR_MISALIGN_TRAP_EN
    check("rst_trap", {31'd0, accessor_trap}, 32'd0);
`endif
    #10 reset_n = 1'b1;
    step();

    // Pass-through: exactly one cycle of latency, no bus activity.
    check("none_pre_valid", {31'd0, accessor_valid}, 32'd0);
    sb.push_back(mk(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0));
    issue(MEM_NONE, WIDTH_WORD, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0);
    check("none_valid", {31'd0, accessor_valid}, 32'd1);
    check("none_no_bus", {31'd0, mem_valid}, 32'd0);
    step();
    check("none_pulse_end", {31'd0, accessor_valid}, 32'd0);
    check("none_no_bus2", {31'd0, mem_valid}, 32'd0);

    // A stray mem_ready while idle must be ignored.
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("stray_ready_valid", {31'd0, accessor_valid}, 32'd0);
    check("stray_ready_idle", {31'd0, accessor_ready}, 32'd1);
    step();
    check("stray_ready_valid2", {31'd0, accessor_valid}, 32'd0);

    // Loads: sign/zero extension across lanes.
    do_load("lb",  WIDTH_BYTE, 1'b0, 5'd10, 32'h0000_0103, 3, 32'h8000_0000, 32'h0000_0100, 32'hFFFF_FF80);
    do_load("lbu", WIDTH_BYTE, 1'b1, 5'd11, 32'h0000_0103, 0, 32'h8000_0000, 32'h0000_0100, 32'h0000_0080);
    do_load("lb1", WIDTH_BYTE, 1'b0, 5'd12, 32'h0000_0011, 1, 32'h0000_7F00, 32'h0000_0010, 32'h0000_007F);
    do_load("lh",  WIDTH_HALF, 1'b0, 5'd13, 32'h0000_0002, 2, 32'h8001_1234, 32'h0000_0000, 32'hFFFF_8001);
    do_load("lhu", WIDTH_HALF, 1'b1, 5'd14, 32'h0000_0002, 0, 32'h8001_1234, 32'h0000_0000, 32'h0000_8001);
    do_load("lh0", WIDTH_HALF, 1'b0, 5'd15, 32'h0000_0040, 0, 32'h8001_1234, 32'h0000_0040, 32'h0000_1234);
    do_load("lw",  WIDTH_WORD, 1'b0, 5'd16, 32'hFFFF_FFFC, 1, 32'h1357_9BDF, 32'hFFFF_FFFC, 32'h1357_9BDF);

    // Stores: lane strobes and replicated data; completion goes to x0.
    do_store("sh", WIDTH_HALF, 32'h0000_0202, 32'h1234_ABCD, 2, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    do_store("sb", WIDTH_BYTE, 32'h0000_0301, 32'h0000_AB55, 0, 32'h0000_0300, 4'b0010, 32'h5555_5555);
    do_store("sw", WIDTH_WORD, 32'h0000_0400, 32'h89AB_CDEF, 1, 32'h0000_0400, 4'b1111, 32'h89AB_CDEF);

    // Held executor_valid during BUS; then two back-to-back pass-through ops.
    wait_ready();
    sb.push_back(mk(5'd9, 32'h1122_3344, 1'b1, 1'b0));
    sb.push_back(mk(5'd7, 32'h0000_0077, 1'b1, 1'b0));
    sb.push_back(mk(5'd8, 32'h0000_0088, 1'b1, 1'b0));
    drive_op(MEM_LOAD, WIDTH_WORD, 1'b0, 5'd9, 32'h0, 32'h0000_0500, 32'h0);
    step();
    drive_op(MEM_NONE, WIDTH_WORD, 1'b0, 5'd7, 32'h0000_0077, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      check("hold_not_ready", {31'd0, accessor_ready}, 32'd0);
      check("hold_no_pulse", {31'd0, accessor_valid}, 32'd0);
      step();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h1122_3344;
    step();
    mem_ready = 1'b0;
    check("hold_load_pulse", {31'd0, accessor_valid}, 32'd1);
    check("hold_ready_back", {31'd0, accessor_ready}, 32'd1);
    step();
    check("b2b_pulse1", {31'd0, accessor_valid}, 32'd1);
    drive_op(MEM_NONE, WIDTH_WORD, 1'b0, 5'd8, 32'h0000_0088, 32'h0, 32'h0);
    step();
    executor_valid = 1'b0;
    check("b2b_pulse2", {31'd0, accessor_valid}, 32'd1);
    step();
    check("b2b_end", {31'd0, accessor_valid}, 32'd0);

    // Misaligned word access.
`ifdef ACCESSOR_MISALIGN_TRAP_EN
    sb.push_back(mk(5'd0, 32'h0000_0101, 1'b1, 1'b1));
    issue(MEM_LOAD, WIDTH_WORD, 1'b0, 5'd20, 32'h0, 32'h0000_0101, 32'h0);
    check("trap_pulse", {31'd0, accessor_valid}, 32'd1);
    check("trap_no_bus", {31'd0, mem_valid}, 32'd0);
    check("trap_ready", {31'd0, accessor_ready}, 32'd1);
    step();
    check("trap_no_bus2", {31'd0, mem_valid}, 32'd0);
`else
    do_load("lw_mis", WIDTH_WORD, 1'b0, 5'd20, 32'h0000_0101, 1, 32'hCAFE_F00D, 32'h0000_0100, 32'hCAFE_F00D);
`endif

    // Reset in BUS abandons the request asynchronously.
    issue(MEM_LOAD, WIDTH_WORD, 1'b0, 5'd21, 32'h0, 32'h0000_0600, 32'h0);
    check("rb_mem_valid", {31'd0, mem_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rb_async_drop", {31'd0, mem_valid}, 32'd0);
    check("rb_ready", {31'd0, accessor_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    repeat (4) step();
    check("rb_no_result", {31'd0, accessor_valid}, 32'd0);

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
